// File: rtl/qkv_phase_ctrl_if.sv
// qkv_phase_ctrl_if: host, engine, attention and SRAM-port bundle
// for the QKV phase controller.
interface qkv_phase_ctrl_if #(
  parameter int NCH    = 3,
  parameter int IN_AW  = 5,
  parameter int W_AW   = 10,
  parameter int OUT_AW = 7
);
  logic                  host_load;
  logic                  host_go;
  logic                  host_rd;
  logic [NCH-1:0]        host_ch_mask;
  logic [IN_AW-1:0]      host_in_addr;
  logic                  host_in_web;
  logic [W_AW-1:0]       host_w_addr;
  logic                  host_w_web;
  logic [OUT_AW-1:0]     host_out_addr;
  logic                  host_out_web;
  logic [NCH*IN_AW-1:0]  proj_in_addr;
  logic [NCH*W_AW-1:0]   proj_w_addr;
  logic [NCH*OUT_AW-1:0] proj_out_addr;
  logic [NCH-1:0]        proj_in_web;
  logic [NCH-1:0]        proj_w_web;
  logic [NCH-1:0]        proj_out_web;
  logic [NCH-1:0]        proj_finished;
  logic [NCH-1:0]        proj_en;
  logic [NCH*OUT_AW-1:0] attn_addr;
  logic                  attn_done;
  logic                  attn_start;
  logic [NCH*IN_AW-1:0]  in_mem_a;
  logic [NCH-1:0]        in_mem_web;
  logic [NCH*W_AW-1:0]   w_mem_a;
  logic [NCH-1:0]        w_mem_web;
  logic [NCH*OUT_AW-1:0] out_mem_a;
  logic [NCH-1:0]        out_mem_web;
  logic [2:0]            state;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output host_load, host_go, host_rd, host_ch_mask,
    output host_in_addr, host_in_web,
    output host_w_addr, host_w_web,
    output host_out_addr, host_out_web,
    output proj_in_addr, proj_w_addr, proj_out_addr,
    output proj_in_web, proj_w_web, proj_out_web,
    output proj_finished, attn_addr, attn_done,
    input  proj_en, attn_start,
    input  in_mem_a, in_mem_web, w_mem_a, w_mem_web,
    input  out_mem_a, out_mem_web,
    input  state, busy, done, err
  );

  modport slave (
    input  host_load, host_go, host_rd, host_ch_mask,
    input  host_in_addr, host_in_web,
    input  host_w_addr, host_w_web,
    input  host_out_addr, host_out_web,
    input  proj_in_addr, proj_w_addr, proj_out_addr,
    input  proj_in_web, proj_w_web, proj_out_web,
    input  proj_finished, attn_addr, attn_done,
    output proj_en, attn_start,
    output in_mem_a, in_mem_web, w_mem_a, w_mem_web,
    output out_mem_a, out_mem_web,
    output state, busy, done, err
  );
endinterface

// File: rtl/qkv_phase_ctrl.sv
// qkv_phase_ctrl: phase FSM and SRAM port arbiter for NCH projection
// channels. Optional hung-phase watchdog: QKV_PHASE_TIMEOUT_EN.
module qkv_phase_ctrl #(
  parameter int NCH     = 3,
  parameter int IN_AW   = 5,
  parameter int W_AW    = 10,
  parameter int OUT_AW  = 7,
  parameter int TIMEOUT = 4096
) (
  input logic             clk,
  input logic             rst,
  qkv_phase_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PROJ = 3'd2;
  localparam logic [2:0] S_ATTN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_RDBK = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0]     r_state;
  logic [2:0]     w_next;
  logic [2:0]     w_st;
  logic [NCH-1:0] r_fin;
  logic [NCH-1:0] w_fin_all;
  logic           w_all_done;
  logic           r_attn_start;

  assign w_fin_all  = r_fin | bus.proj_finished;
  assign w_all_done = &w_fin_all;
  // Routing sees IDLE while rst is high so no write leaks in that cycle.
  assign w_st       = rst ? S_IDLE : r_state;

`ifdef QKV_PHASE_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_to;

  assign w_to = ((r_state == S_PROJ) || (r_state == S_ATTN))
             && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (w_next == S_ERR);
      if (w_next != r_state)
        r_cnt <= '0;
      else if ((r_state == S_PROJ) || (r_state == S_ATTN))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign bus.err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.host_load) w_next = S_LOAD;
      S_LOAD: if (bus.host_go) w_next = S_PROJ;
      S_PROJ: if (w_all_done) w_next = S_ATTN;
      S_ATTN: if (bus.attn_done) w_next = S_DONE;
      S_DONE: begin
        if (bus.host_load)    w_next = S_LOAD;
        else if (bus.host_rd) w_next = S_RDBK;
      end
      S_RDBK: if (!bus.host_rd) w_next = S_DONE;
      S_ERR:  if (bus.host_load) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
`ifdef QKV_PHASE_TIMEOUT_EN
    if (w_to) w_next = S_ERR;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_fin        <= '0;
      r_attn_start <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_attn_start <= (r_state == S_PROJ) && (w_next == S_ATTN);
      if ((r_state == S_LOAD) && bus.host_go)
        r_fin <= '0;
      else if (r_state == S_PROJ)
        r_fin <= w_fin_all;
    end
  end

  always_comb begin
    bus.in_mem_a    = '0;
    bus.in_mem_web  = '1;
    bus.w_mem_a     = '0;
    bus.w_mem_web   = '1;
    bus.out_mem_a   = '0;
    bus.out_mem_web = '1;
    bus.proj_en     = '0;
    for (int c = 0; c < NCH; c++) begin
      unique case (w_st)
        S_LOAD: begin
          bus.in_mem_a[c*IN_AW +: IN_AW] = bus.host_in_addr;
          bus.in_mem_web[c] =
            bus.host_in_web | ~bus.host_ch_mask[c];
          bus.w_mem_a[c*W_AW +: W_AW] = bus.host_w_addr;
          bus.w_mem_web[c] =
            bus.host_w_web | ~bus.host_ch_mask[c];
          bus.out_mem_a[c*OUT_AW +: OUT_AW] = bus.host_out_addr;
          bus.out_mem_web[c] =
            bus.host_out_web | ~bus.host_ch_mask[c];
        end
        S_PROJ: begin
          bus.in_mem_a[c*IN_AW +: IN_AW] =
            bus.proj_in_addr[c*IN_AW +: IN_AW];
          bus.in_mem_web[c] = bus.proj_in_web[c];
          bus.w_mem_a[c*W_AW +: W_AW] =
            bus.proj_w_addr[c*W_AW +: W_AW];
          bus.w_mem_web[c] = bus.proj_w_web[c];
          bus.out_mem_a[c*OUT_AW +: OUT_AW] =
            bus.proj_out_addr[c*OUT_AW +: OUT_AW];
          bus.out_mem_web[c] = bus.proj_out_web[c];
          bus.proj_en[c] = ~r_fin[c];
        end
        S_ATTN: begin
          bus.out_mem_a[c*OUT_AW +: OUT_AW] =
            bus.attn_addr[c*OUT_AW +: OUT_AW];
        end
        S_RDBK: begin
          // Only selected channels see the host readback address.
          if (bus.host_ch_mask[c])
            bus.out_mem_a[c*OUT_AW +: OUT_AW] = bus.host_out_addr;
          bus.out_mem_web[c] =
            bus.host_out_web | ~bus.host_ch_mask[c];
        end
        default: ;
      endcase
    end
  end

  assign bus.attn_start = r_attn_start;
  assign bus.state      = r_state;
  assign bus.busy       = (w_st == S_PROJ) || (w_st == S_ATTN);
  assign bus.done       = (w_st == S_DONE);

endmodule

// File: doc/qkv_phase_ctrl.md
# qkv_phase_ctrl

Parametrised phase controller and SRAM port arbiter for the multi-head attention front end. It owns the input, weight and projection-output SRAM ports of NCH projection channels (Q/K/V by default). Across the load, project, attend and readback phases it routes those ports to the host, the projection engines or the attention reader. It also latches per-channel completion stickily and launches attention exactly once, and can optionally abort on a hung phase.

## Interface
- NCH, 3, number of projection channels
- IN_AW, 5, input SRAM address width
- W_AW, 10, weight SRAM address width
- OUT_AW, 7, projection-output SRAM address width
- TIMEOUT, 4096, watchdog limit in cycles (used only with the macro)

Clock and reset: one clock; reset is synchronous and active-high.

All *_web signals are active-low write enables: 0 = write, 1 = read.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- host_load  in  1  request the LOAD phase (level)
- host_go  in  1  start projection (pulse)
- host_rd  in  1  hold the readback phase (level)
- host_ch_mask  in  NCH  channels that receive host writes (multiple bits set = broadcast)
- host_in_addr / host_in_web  in  IN_AW / 1  host input-SRAM port
- host_w_addr / host_w_web  in  W_AW / 1  host weight-SRAM port
- host_out_addr / host_out_web  in  OUT_AW / 1  host output-SRAM port
- proj_in_addr, proj_w_addr, proj_out_addr  in  NCH*IN_AW, NCH*W_AW, NCH*OUT_AW  engine addresses, channel c at slice c
- proj_in_web, proj_w_web, proj_out_web  in  NCH each  engine write enables
- proj_finished  in  NCH  engine completion (pulse or level)
- proj_en  out  NCH  engine enable
- attn_addr  in  NCH*OUT_AW  attention reader addresses
- attn_done  in  1  attention complete (pulse)
- attn_start  out  1  one-cycle attention launch
- in_mem_a / in_mem_web  out  NCH*IN_AW / NCH  input SRAM ports
- w_mem_a / w_mem_web  out  NCH*W_AW / NCH  weight SRAM ports
- out_mem_a / out_mem_web  out  NCH*OUT_AW / NCH  output SRAM ports
- state  out  3  current phase encoding
- busy, done, err  out  1 each  status

## Operation
State encodings: IDLE=0, LOAD=1, PROJ=2, ATTN=3, DONE=4, RDBK=5, ERR=6.

Transitions:
- IDLE: host_load -> LOAD.
- LOAD: host_go -> PROJ; clears fin_sticky[NCH].
- PROJ: fin_sticky[c] is set on proj_finished[c]. When every bit of (fin_sticky | proj_finished) is 1 -> ATTN, with attn_start asserted in the first ATTN cycle.
- ATTN: attn_done -> DONE.
- DONE: host_load -> LOAD (priority), else host_rd -> RDBK.
- RDBK: !host_rd -> DONE.

Port routing per channel c. Anything not listed drives address 0 and web=1.
- LOAD: in/w ports follow the host ports. web = host web if host_ch_mask[c], else 1. Out ports follow the host out port, masked the same way.
- PROJ: all three ports pass through proj_*[c].
- ATTN: out_mem_a = attn_addr slice c; out_mem_web forced to 1.
- RDBK: out ports follow the host out port; web is masked by host_ch_mask.

Other rules:
- proj_en[c] = (state==PROJ) & ~fin_sticky[c]. A finished channel is idled while the others continue.
- busy = state in {PROJ, ATTN}. done = state==DONE.
- Events arriving outside their state are ignored: host_go outside LOAD, attn_done outside ATTN, proj_finished outside PROJ.

## Timing
- state, fin_sticky, attn_start and err are registered. Routing, proj_en, busy and done are combinational from the registered state plus inputs, so there are zero cycles of address latency through the mux.
- Reset values: state=IDLE, fin_sticky=0, attn_start=0, err=0, proj_en=0, busy=0, done=0, all webs=1, all addresses=0.
- If the last proj_finished arrives in cycle t, ATTN is entered and attn_start=1 in cycle t+1, for exactly one cycle.
- Simultaneous finishes across channels in one cycle are counted together.
- host_go and host_load in the same LOAD cycle: go wins.
- rst asserted mid-phase returns to IDLE on the next edge; no write-enable is asserted during the reset cycle.

## Configuration
- QKV_PHASE_TIMEOUT_EN defined: a cycle counter clears on every state change and counts in PROJ and ATTN. On reaching TIMEOUT-1 the block goes to ERR; err=1 is sticky and all webs are 1. ERR -> LOAD on host_load, which clears err.
- Macro undefined: no counter, err tied 0, ERR unreachable.

## Test plan
- Reset, then idle 10 cycles -> state=0, all webs 1, proj_en=0, attn_start never 1.
- LOAD with host_ch_mask=3'b111, host_in_web=0, addr 5 -> in_mem_web=3'b000, in_mem_a=5 on all three slices the same cycle.
- host_go; proj_finished at cycles 10, 14, 14 for ch0, ch1, ch2 -> proj_en[0]=0 from cycle 11; attn_start a single pulse at cycle 15.
- ATTN with attn_addr slices 7/8/9 and proj_out_web=0 driven -> out_mem_a=7/8/9, out_mem_web=3'b111.
- DONE, host_rd=1, host_ch_mask=3'b010, host_out_addr=42 -> out_mem_a slice1=42 with others 0; RDBK exits one cycle after host_rd drops.
- With QKV_PHASE_TIMEOUT_EN and TIMEOUT=16, ch2 never finishes -> ERR at PROJ-entry+16, err=1 until host_load.
